// File: rtl/sign_merge_if.sv
// Operand/result bundle for the sign-bit merge pipeline.
// The master drives operands and the mode bit; the slave returns the result and the drop count.
interface sign_merge_if #(
   parameter int WIDTH = 32,
   parameter int CW    = 8
) ();
   logic             in_valid;
   logic [WIDTH-1:0] opa;
   logic [WIDTH-1:0] opb;
   logic             fast;
   logic [WIDTH-1:0] out;
   logic             out_valid;
   logic [CW-1:0]    drop_cnt;

   modport master (
      output in_valid, opa, opb, fast,
      input  out, out_valid, drop_cnt
   );

   modport slave (
      input  in_valid, opa, opb, fast,
      output out, out_valid, drop_cnt
   );
endinterface

// File: rtl/sign_merge_pipe.sv
// Sums the operand sign bits, or forces zero when either kill bit is set,
// then carries the result through a valid-tagged pipeline with a fast bypass.
module sign_merge_pipe #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 3,
   parameter int CW    = 8
) (
   input logic          clk,
   input logic          rst,
   sign_merge_if.slave  bus
);
   localparam int PW = $clog2(DEPTH + 1);
   localparam int SW = ((CW > PW) ? CW : PW) + 1;
   localparam logic [SW-1:0] SAT = SW'({CW{1'b1}});

   logic [1:0]       m;
   logic             kill;
   logic [WIDTH-1:0] merged;

   logic [WIDTH-1:0] sd [1:DEPTH];
   logic [DEPTH:1]   sv;

   logic [WIDTH-1:0] out_q;
   logic             out_valid_q;
   logic [CW-1:0]    drop_q;

   logic [PW-1:0]    pop;
   logic [SW-1:0]    drop_sum;
   logic [CW-1:0]    drop_nx;

   // Only the two top bits of each operand influence the result.
   logic unused_low_bits;
   assign unused_low_bits = ^{bus.opa[WIDTH-3:0], bus.opb[WIDTH-3:0]};

   assign m      = {1'b0, bus.opa[WIDTH-1]} + {1'b0, bus.opb[WIDTH-1]};
   assign kill   = bus.opa[WIDTH-2] | bus.opb[WIDTH-2];
   assign merged = kill ? '0 : {{(WIDTH-2){1'b0}}, m};

   // Valid entries beyond stage 1 are what a fast-mode edge discards.
   always_comb begin
      pop = '0;
      for (int k = 2; k <= DEPTH; k++) begin
         pop = pop + PW'(sv[k]);
      end
   end

   always_comb begin
      drop_sum = SW'(drop_q) + SW'(pop);
      drop_nx  = drop_q;
      if (drop_sum > SAT) begin
         drop_nx = '1;
      end else begin
         drop_nx = drop_sum[CW-1:0];
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int k = 1; k <= DEPTH; k++) begin
            sd[k] <= '0;
         end
         sv          <= '0;
         out_q       <= '0;
         out_valid_q <= 1'b0;
         drop_q      <= '0;
      end else begin
         sv[1] <= bus.in_valid;
         sd[1] <= merged;
         if (bus.fast) begin
            if (sv[1]) begin
               out_q <= sd[1];
            end
            out_valid_q <= sv[1];
            for (int k = 2; k <= DEPTH; k++) begin
               sv[k] <= 1'b0;
            end
            drop_q <= drop_nx;
         end else begin
            for (int k = 2; k <= DEPTH; k++) begin
               sv[k] <= sv[k-1];
               sd[k] <= sd[k-1];
            end
            if (sv[DEPTH]) begin
               out_q <= sd[DEPTH];
            end
            out_valid_q <= sv[DEPTH];
         end
      end
   end

   assign bus.out       = out_q;
   assign bus.out_valid = out_valid_q;
   assign bus.drop_cnt  = drop_q;
endmodule

// File: tb/tb_sign_merge_pipe.sv
// Scoreboard bench: a driver steps an age-based reference model per edge and
// queues expectations; a monitor checks the DUT after each edge.
module tb_sign_merge_pipe;
   localparam int WIDTH = 32;
   localparam int DEPTH = 3;
   localparam int CW    = 2;
   localparam int DMAX  = (1 << CW) - 1;

   typedef struct { int ed; logic [WIDTH-1:0] val; } rec_t;
   typedef struct { int ed; int cnt; } drec_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   edge_cnt = 0;
   int   total = 0;
   int   bad = 0;

   rec_t  pend[$];
   rec_t  exp_q[$];
   drec_t drop_q[$];
   int    mdl_drop = 0;
   logic [WIDTH-1:0] last_out = '0;

   sign_merge_if #(.WIDTH(WIDTH), .CW(CW)) bus ();

   sign_merge_pipe #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CW(CW)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;
   always @(posedge clk) edge_cnt <= edge_cnt + 1;

   task automatic chk(input string name, input longint act, input longint req);
      total++;
      if (act != req) begin
         bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, req, $time);
      end
   endtask

   task automatic flag(input string name, input longint act, input longint req);
      total++;
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, req, $time);
   endtask

   function automatic logic [WIDTH-1:0] ref_merge(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
      int s;
      if (a[WIDTH-2] || b[WIDTH-2]) return '0;
      s = int'(a[WIDTH-1]) + int'(b[WIDTH-1]);
      return WIDTH'(s);
   endfunction

   // Model for the upcoming edge e: an entry sampled at edge x sits in stage e-x.
   task automatic model_edge(input logic iv, input logic [WIDTH-1:0] a,
                             input logic [WIDTH-1:0] b, input logic f);
      int e;
      e = edge_cnt;
      bus.in_valid = iv;
      bus.opa      = a;
      bus.opb      = b;
      bus.fast     = f;
      if (f) begin
         foreach (pend[i]) begin
            if (pend[i].ed == e - 1) exp_q.push_back('{e, pend[i].val});
            else mdl_drop = (mdl_drop + 1 > DMAX) ? DMAX : mdl_drop + 1;
         end
         pend.delete();
      end else if (pend.size() > 0 && pend[0].ed == e - DEPTH) begin
         exp_q.push_back('{e, pend[0].val});
         void'(pend.pop_front());
      end
      if (iv) pend.push_back('{e, ref_merge(a, b)});
      drop_q.push_back('{e, mdl_drop});
   endtask

   task automatic step(input logic iv, input logic [WIDTH-1:0] a,
                       input logic [WIDTH-1:0] b, input logic f);
      @(negedge clk);
      model_edge(iv, a, b, f);
   endtask

   task automatic idle(input int n, input logic f);
      for (int i = 0; i < n; i++) step(1'b0, '0, '0, f);
   endtask

   task automatic release_rst();
      @(negedge clk);
      rst = 1'b0;
      model_edge(1'b0, '0, '0, 1'b0);
   endtask

   task automatic async_reset();
      @(negedge clk);
      #2;
      rst = 1'b1;
      #1;
      chk("rst_out", bus.out, 0);
      chk("rst_out_valid", bus.out_valid, 0);
      chk("rst_drop_cnt", bus.drop_cnt, 0);
      pend.delete();
      exp_q.delete();
      drop_q.delete();
      mdl_drop = 0;
      repeat (2) @(posedge clk);
      release_rst();
   endtask

   task automatic mode_switch();
      step(1'b1, 32'h8000_0000, 32'h8000_0000, 1'b0);
      step(1'b1, 32'h8000_0000, 32'h0000_0000, 1'b0);
      step(1'b0, '0, '0, 1'b1);
      idle(2, 1'b0);
   endtask

   // Monitor: one drop-count record per edge, one expectation per out pulse.
   initial begin
      rec_t  r;
      drec_t d;
      int    cur;
      forever begin
         @(posedge clk);
         #1;
         if (rst) begin
            last_out = '0;
            continue;
         end
         cur = edge_cnt - 1;
         if (drop_q.size() == 0) begin
            flag("drop_record_missing", cur, -1);
         end else begin
            d = drop_q.pop_front();
            chk("drop_cnt", bus.drop_cnt, d.cnt);
         end
         if (bus.out_valid) begin
            if (exp_q.size() == 0) begin
               flag("unexpected_pulse", cur, -1);
            end else begin
               r = exp_q.pop_front();
               chk("out_value", bus.out, r.val);
               chk("out_latency", cur, r.ed);
               last_out = r.val;
            end
         end else begin
            if (exp_q.size() > 0 && exp_q[0].ed <= cur) begin
               flag("missing_pulse", cur, exp_q[0].ed);
               void'(exp_q.pop_front());
            end
            chk("out_hold", bus.out, last_out);
         end
      end
   end

   initial begin
      logic [WIDTH-1:0] a, b;
      bus.in_valid = 1'b0;
      bus.opa      = '0;
      bus.opb      = '0;
      bus.fast     = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("init_out", bus.out, 0);
      chk("init_out_valid", bus.out_valid, 0);
      chk("init_drop_cnt", bus.drop_cnt, 0);
      release_rst();

      // Normal-mode sum, then both kill forms.
      step(1'b1, 32'h8000_0000, 32'h8000_0000, 1'b0);
      idle(5, 1'b0);
      step(1'b1, 32'hC000_0000, 32'h8000_0000, 1'b0);
      step(1'b1, 32'h0000_0000, 32'h4000_0000, 1'b0);
      idle(5, 1'b0);

      // Fast mode, single and streamed.
      step(1'b1, 32'h8000_0000, 32'h0000_0000, 1'b1);
      idle(3, 1'b1);
      for (int i = 0; i < 4; i++) step(1'b1, 32'h8000_0000, (i % 2) ? 32'h8000_0000 : 32'h0, 1'b1);
      idle(3, 1'b1);
      idle(2, 1'b0);

      // Mode switch drops the older entry; repeated until the counter saturates.
      for (int i = 0; i < 5; i++) mode_switch();

      // Mid-stream asynchronous reset.
      for (int i = 0; i < 3; i++) step(1'b1, 32'h8000_0000, 32'h8000_0000, 1'b0);
      async_reset();
      idle(5, 1'b0);

      // Random traffic with random mode switching.
      for (int i = 0; i < 400; i++) begin
         a = $urandom;
         b = $urandom;
         if ($urandom_range(0, 1) == 1) begin
            a[WIDTH-2] = 1'b0;
            b[WIDTH-2] = 1'b0;
         end
         step($urandom_range(0, 3) != 0, a, b, $urandom_range(0, 4) == 0);
         if (i == 200) async_reset();
      end
      idle(DEPTH + 3, 1'b0);
      @(posedge clk);
      #2;
      chk("drained", exp_q.size(), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
